// File: rtl/pbi_device_responder.sv
// pbi_device_responder
// Device-side responder for the PBI expansion bus. PHI2/RW are brought into the
// Clk domain and a small FSM walks each bus cycle through settle, active-decode and
// commit phases. When this device is selected through its bit of the D1FF register,
// it takes over the D800-DFFF ROM window and decodes D1xx register accesses. It also
// reports and drives the pending-interrupt status.
//
// Bus handshake: a bus cycle is framed by PHI2 alone, and there is no ready/stall path
// back to the host. Decode outputs are valid only while dbg_state shows ACTIVE. Write
// side-effects (the Selected update and the RegWr strobe) happen exactly once, on the
// Clk edge that leaves COMMIT. A cycle aborted in SETTLE, or cut short by a bus stall,
// never commits.
module pbi_device_responder #(
    parameter int DEVICE_ID     = 0,
    parameter int SETTLE_CYCLES = 3,
    parameter int STALL_CYCLES  = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PHI2,
    input  logic        RW,
    input  logic [15:0] Addr,
    input  logic [7:0]  DataIn,
    input  logic        IrqReq,
    input  logic        IrqAck,
    output logic        EXTSEL_n,
    output logic        MPD_n,
    output logic        IRQ_n,
    output logic [7:0]  DataOut,
    output logic [7:0]  DataMask,
    output logic        RomCS,
    output logic        RegSel,
    output logic        RegWr,
    output logic [7:0]  RegAddr,
    output logic [7:0]  RegWData,
    output logic [1:0]  dbg_state
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STALL_LIMIT = TW'(STALL_CYCLES);
    localparam logic [7:0]    DEV_BIT     = 8'h01 << DEVICE_ID;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] stall_cnt;

    logic          phi2_s1, phi2_s2, phi2_d;
    logic          rw_s1, rw_s2;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;

    logic          selected;
    logic          irq_pending;
    logic          irq_req_d;

    // Write intent captured during ACTIVE and consumed in COMMIT
    logic          wr_d1ff;
    logic          wr_reg;
    logic [7:0]    wdata_hold;

    logic          phi2_rise, phi2_fall, phi2_edge, stall;
    logic          dec_rom, dec_d1ff, dec_reg, dec_status, dec_en;

    assign dbg_state = state;

    assign phi2_rise = phi2_s2 & ~phi2_d;
    assign phi2_fall = ~phi2_s2 & phi2_d;
    assign phi2_edge = phi2_rise | phi2_fall;
    assign stall     = (stall_cnt == STALL_LIMIT) && !phi2_edge;

    assign dec_d1ff   = (addr_q == 16'hD1FF);
    assign dec_rom    = selected && (addr_q[15:11] == 5'b11011);
    assign dec_reg    = selected && (addr_q[15:8] == 8'hD1) && !dec_d1ff;
    assign dec_status = dec_d1ff && rw_s2;

    // Decode outputs are loaded on entry to ACTIVE and refreshed while it lasts
    assign dec_en = !stall &&
                    (((state == S_SETTLE) && !phi2_fall && (settle_cnt == SETTLE_LAST)) ||
                     ((state == S_ACTIVE) && !phi2_fall));

    // Bring PHI2/RW into the Clk domain and register Addr/DataIn every Clk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phi2_s1 <= 1'b0;
            phi2_s2 <= 1'b0;
            phi2_d  <= 1'b0;
            rw_s1   <= 1'b1;
            rw_s2   <= 1'b1;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
        end else begin
            phi2_s1 <= PHI2;
            phi2_s2 <= phi2_s1;
            phi2_d  <= phi2_s2;
            rw_s1   <= RW;
            rw_s2   <= rw_s1;
            addr_q  <= Addr;
            data_q  <= DataIn;
        end
    end

    // Count Clk cycles since the last PHI2 edge, saturating at the stall limit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt <= '0;
        end else if (phi2_edge) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_LIMIT) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bus-cycle FSM with registered decode outputs and commit side-effects
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            selected   <= 1'b0;
            wr_d1ff    <= 1'b0;
            wr_reg     <= 1'b0;
            wdata_hold <= 8'h00;
            RomCS      <= 1'b0;
            EXTSEL_n   <= 1'b1;
            RegSel     <= 1'b0;
            RegAddr    <= 8'h00;
            DataMask   <= 8'h00;
            DataOut    <= 8'h00;
            RegWr      <= 1'b0;
            RegWData   <= 8'h00;
        end else begin
            RegWr <= 1'b0;

            if (stall) begin
                state   <= S_IDLE;
                wr_d1ff <= 1'b0;
                wr_reg  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (phi2_rise) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (phi2_fall) begin
                            state <= S_IDLE;
                        end else if (settle_cnt == SETTLE_LAST) begin
                            state <= S_ACTIVE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        // The last ACTIVE edge leaves the final write intent and data
                        wr_d1ff    <= dec_d1ff && !rw_s2;
                        wr_reg     <= dec_reg && !rw_s2;
                        wdata_hold <= data_q;
                        if (phi2_fall) begin
                            state <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        state <= S_IDLE;
                        if (wr_d1ff) begin
                            selected <= wdata_hold[DEVICE_ID];
                        end
                        if (wr_reg) begin
                            RegWr    <= 1'b1;
                            RegWData <= wdata_hold;
                        end
                        wr_d1ff <= 1'b0;
                        wr_reg  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end

            if (dec_en) begin
                RomCS    <= dec_rom;
                EXTSEL_n <= !dec_rom;
                RegSel   <= dec_reg;
                DataMask <= dec_status ? DEV_BIT : 8'h00;
                DataOut  <= (dec_status && irq_pending) ? DEV_BIT : 8'h00;
                if (dec_reg) begin
                    RegAddr <= addr_q[7:0];
                end
            end else begin
                RomCS    <= 1'b0;
                EXTSEL_n <= 1'b1;
                RegSel   <= 1'b0;
                DataMask <= 8'h00;
                DataOut  <= 8'h00;
            end
        end
    end

    // Math-pack disable follows Selected one Clk later, regardless of bus activity
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            MPD_n <= 1'b1;
        end else begin
            MPD_n <= !selected;
        end
    end

    // Pending IRQ: set on a rising IrqReq, cleared by IrqAck, and a new request wins a tie
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_req_d   <= 1'b0;
            irq_pending <= 1'b0;
            IRQ_n       <= 1'b1;
        end else begin
            irq_req_d <= IrqReq;
            if (IrqReq && !irq_req_d) begin
                irq_pending <= 1'b1;
            end else if (IrqAck) begin
                irq_pending <= 1'b0;
            end
            IRQ_n <= !irq_pending;
        end
    end

endmodule

// File: tb/tb_pbi_device_responder.sv
// Testbench for pbi_device_responder: directed table of bus cycles, hand-written
// stall/reset/short-pulse/IRQ sequences, then randomized bus cycles checked against
// a small model of the device-select and IRQ rules.
module tb_pbi_device_responder;

    localparam int DEV = 0;
    localparam int HIGH_CLKS = 12;
    localparam int LOW_CLKS  = 10;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        PHI2;
    logic        RW;
    logic [15:0] Addr;
    logic [7:0]  DataIn;
    logic        IrqReq;
    logic        IrqAck;
    logic        EXTSEL_n, MPD_n, IRQ_n, RomCS, RegSel, RegWr;
    logic [7:0]  DataOut, DataMask, RegAddr, RegWData;
    logic [1:0]  dbg_state;

    pbi_device_responder #(
        .DEVICE_ID(DEV), .SETTLE_CYCLES(3), .STALL_CYCLES(64)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PHI2(PHI2), .RW(RW), .Addr(Addr),
        .DataIn(DataIn), .IrqReq(IrqReq), .IrqAck(IrqAck), .EXTSEL_n(EXTSEL_n),
        .MPD_n(MPD_n), .IRQ_n(IRQ_n), .DataOut(DataOut), .DataMask(DataMask),
        .RomCS(RomCS), .RegSel(RegSel), .RegWr(RegWr), .RegAddr(RegAddr),
        .RegWData(RegWData), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic        exp_rom;
        logic        exp_reg;
        logic [7:0]  exp_mask;
        logic [7:0]  exp_dout;
        int          exp_wr;
        logic [7:0]  exp_raddr;
        logic [7:0]  exp_wdata;
        logic        exp_mpd_n;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered over one bus cycle
    logic       rom_seen, ext_seen, reg_seen;
    logic [7:0] mask_seen, dout_seen, raddr_seen, wdata_seen;
    int         wr_count;

    // Behavioural model state
    logic m_sel  = 1'b0;
    logic m_pend = 1'b0;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic sample_cycle();
        if (RomCS) rom_seen = 1'b1;
        if (!EXTSEL_n) ext_seen = 1'b1;
        if (RegSel) begin
            reg_seen   = 1'b1;
            raddr_seen = RegAddr;
        end
        mask_seen = mask_seen | DataMask;
        dout_seen = dout_seen | DataOut;
        if (RegWr) begin
            wr_count++;
            wdata_seen = RegWData;
        end
    endtask

    // Drive one PHI2 high/low period with the given address, direction and data
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             input int high_clks, input int low_clks);
        rom_seen = 1'b0; ext_seen = 1'b0; reg_seen = 1'b0;
        mask_seen = 8'h00; dout_seen = 8'h00; raddr_seen = 8'h00;
        wdata_seen = 8'h00; wr_count = 0;
        @(negedge Clk);
        Addr = a; RW = rw; DataIn = d; PHI2 = 1'b1;
        repeat (high_clks) begin
            @(negedge Clk);
            sample_cycle();
        end
        PHI2 = 1'b0;
        repeat (low_clks) begin
            @(negedge Clk);
            sample_cycle();
        end
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        bus_cycle(v.addr, v.rw, v.data, HIGH_CLKS, LOW_CLKS);
        chk(tag, "RomCS", {31'd0, rom_seen}, {31'd0, v.exp_rom});
        chk(tag, "EXTSEL_n_low", {31'd0, ext_seen}, {31'd0, v.exp_rom});
        chk(tag, "RegSel", {31'd0, reg_seen}, {31'd0, v.exp_reg});
        if (v.exp_reg) chk(tag, "RegAddr", {24'd0, raddr_seen}, {24'd0, v.exp_raddr});
        chk(tag, "DataMask", {24'd0, mask_seen}, {24'd0, v.exp_mask});
        chk(tag, "DataOut", {24'd0, dout_seen}, {24'd0, v.exp_dout});
        chk(tag, "RegWr_count", wr_count, v.exp_wr);
        if (v.exp_wr != 0) chk(tag, "RegWData", {24'd0, wdata_seen}, {24'd0, v.exp_wdata});
        chk(tag, "MPD_n", {31'd0, MPD_n}, {31'd0, v.exp_mpd_n});
        chk(tag, "quiet_after", {22'd0, RomCS, RegSel, DataMask},
            {22'd0, 1'b0, 1'b0, 8'h00});
    endtask

    // Expected outcome of a full-length bus cycle, derived from the device rules
    task automatic model_vec(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             output vec_t v);
        logic in_rom, is_status, in_d1;
        in_rom    = (a >= 16'hD800) && (a <= 16'hDFFF);
        is_status = (a == 16'hD1FF);
        in_d1     = (a >= 16'hD100) && (a <= 16'hD1FE);
        v.addr      = a;
        v.rw        = rw;
        v.data      = d;
        v.exp_rom   = m_sel && in_rom;
        v.exp_reg   = m_sel && in_d1;
        v.exp_mask  = (is_status && rw) ? 8'(2 ** DEV) : 8'h00;
        v.exp_dout  = (is_status && rw && m_pend) ? 8'(2 ** DEV) : 8'h00;
        v.exp_wr    = (m_sel && in_d1 && !rw) ? 1 : 0;
        v.exp_raddr = a[7:0];
        v.exp_wdata = d;
        if (is_status && !rw) m_sel = d[DEV];
        v.exp_mpd_n = !m_sel;
    endtask

    task automatic irq_rise();
        @(negedge Clk); IrqReq = 1'b1;
        @(negedge Clk); IrqReq = 1'b0;
        repeat (3) @(negedge Clk);
        m_pend = 1'b1;
    endtask

    task automatic irq_ack();
        @(negedge Clk); IrqAck = 1'b1;
        @(negedge Clk); IrqAck = 1'b0;
        repeat (3) @(negedge Clk);
        m_pend = 1'b0;
    endtask

    vec_t table_v[8];
    vec_t v;

    initial begin
        // Directed table (DEVICE_ID = 0), starting deselected with no IRQ pending
        //               addr      rw    data   rom   reg   mask   dout  wr raddr  wdata  mpd_n
        table_v[0] = '{16'hD1FF, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b0};
        table_v[1] = '{16'hD800, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b0};
        table_v[2] = '{16'hD140, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h40, 8'h5A, 1'b0};
        table_v[3] = '{16'hD1FF, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 1'b0};
        table_v[4] = '{16'hD1FF, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1};
        table_v[5] = '{16'hDC00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1};
        table_v[6] = '{16'hD140, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1};
        table_v[7] = '{16'hD1FF, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 1'b1};

        // Reset
        Reset_n = 1'b0; PHI2 = 1'b0; RW = 1'b1; Addr = 16'h0000; DataIn = 8'h00;
        IrqReq = 1'b0; IrqAck = 1'b0;
        repeat (4) @(negedge Clk);
        chk("reset", "outputs",
            {EXTSEL_n, MPD_n, IRQ_n, RomCS, RegSel, RegWr, DataOut, DataMask, RegAddr, RegWData},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        chk("reset", "state", {30'd0, dbg_state}, 32'd0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            run_and_check(table_v[i], $sformatf("table%0d", i));
        end
        m_sel = 1'b0;

        // IRQ: raise, read status, ack racing a new request, then plain ack
        irq_rise();
        chk("irq", "IRQ_n_set", {31'd0, IRQ_n}, 32'd0);
        model_vec(16'hD1FF, 1'b1, 8'h00, v);
        run_and_check(v, "irq_status");
        @(negedge Clk); IrqAck = 1'b1; IrqReq = 1'b1;
        @(negedge Clk); IrqAck = 1'b0;
        repeat (3) @(negedge Clk);
        chk("irq", "IRQ_n_set_wins", {31'd0, IRQ_n}, 32'd0);
        IrqReq = 1'b0;
        irq_ack();
        chk("irq", "IRQ_n_cleared", {31'd0, IRQ_n}, 32'd1);

        // Stall: PHI2 held high through an ACTIVE D800 read
        model_vec(16'hD1FF, 1'b0, 8'h01, v);
        run_and_check(v, "stall_sel");
        @(negedge Clk);
        Addr = 16'hD800; RW = 1'b1; PHI2 = 1'b1;
        repeat (20) @(negedge Clk);
        chk("stall", "RomCS_before", {31'd0, RomCS}, 32'd1);
        chk("stall", "EXTSEL_n_before", {31'd0, EXTSEL_n}, 32'd0);
        repeat (70) @(negedge Clk);
        chk("stall", "RomCS_after", {31'd0, RomCS}, 32'd0);
        chk("stall", "EXTSEL_n_after", {31'd0, EXTSEL_n}, 32'd1);
        chk("stall", "state_idle", {30'd0, dbg_state}, 32'd0);
        chk("stall", "MPD_n_kept", {31'd0, MPD_n}, 32'd0);
        PHI2 = 1'b0;
        repeat (10) @(negedge Clk);
        model_vec(16'hD900, 1'b1, 8'h00, v);
        run_and_check(v, "stall_recover");

        // Short PHI2 pulses abort in SETTLE and never commit
        bus_cycle(16'hD1FF, 1'b0, 8'h00, 2, LOW_CLKS);
        chk("short", "MPD_n_kept", {31'd0, MPD_n}, 32'd0);
        bus_cycle(16'hD140, 1'b0, 8'h33, 2, LOW_CLKS);
        chk("short", "RegWr_count", wr_count, 0);
        chk("short", "RegSel", {31'd0, reg_seen}, 32'd0);

        // Reset asserted in the middle of an ACTIVE ROM read
        @(negedge Clk);
        Addr = 16'hDABC; RW = 1'b1; PHI2 = 1'b1;
        repeat (10) @(negedge Clk);
        chk("midreset", "RomCS_active", {31'd0, RomCS}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("midreset", "outputs",
            {EXTSEL_n, MPD_n, IRQ_n, RomCS, RegSel, RegWr, DataOut, DataMask, RegAddr, RegWData},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        chk("midreset", "state", {30'd0, dbg_state}, 32'd0);
        @(negedge Clk);
        PHI2 = 1'b0; Reset_n = 1'b1;
        m_sel = 1'b0; m_pend = 1'b0;
        repeat (5) @(negedge Clk);
        chk("midreset", "MPD_n_deselected", {31'd0, MPD_n}, 32'd1);

        // Randomized bus cycles against the model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic        rw;
            logic [7:0]  d;
            int          irq_op;
            irq_op = $urandom_range(0, 3);
            if (irq_op == 0) irq_rise();
            else if (irq_op == 1) irq_ack();
            case ($urandom_range(0, 3))
                0:       a = 16'hD800 + 16'($urandom_range(0, 16'h07FF));
                1:       a = 16'hD100 + 16'($urandom_range(0, 8'hFE));
                2:       a = 16'hD1FF;
                default: a = 16'($urandom_range(0, 16'hD0FF));
            endcase
            rw = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            model_vec(a, rw, d, v);
            run_and_check(v, $sformatf("rand%0d", i));
            chk($sformatf("rand%0d", i), "IRQ_n", {31'd0, IRQ_n}, {31'd0, !m_pend});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
